// File: rtl/vdma_wr_port_arbiter.sv
// vdma_wr_port_arbiter
// Merges the AXI4 write sides of NUM_CH vdma ports onto one AXI4 master.
// Bursts are granted round-robin, W is locked to the granted burst, AW is
// tagged with the channel index and B is routed back by ID. Each channel is
// limited to MAX_OUTST bursts whose AW was accepted but whose B is pending.
// Optional feature: define VDMA_WR_ARB_LEN_CHK_EN to enforce burst length
// against awlen and report violations on the sticky len_err output.
module vdma_wr_port_arbiter #(
  parameter int NUM_CH         = 4,
  parameter int ASIZE          = 29,
  parameter int BURST_LEN_SIZE = 8,
  parameter int AXI_DSIZE      = 256,
  parameter int MAX_OUTST      = 4,
  localparam int IDSIZE        = $clog2(NUM_CH)
) (
  input  logic                               axi_aclk,
  input  logic                               axi_resetn,
  input  logic [NUM_CH*ASIZE-1:0]            s_awaddr,
  input  logic [NUM_CH*BURST_LEN_SIZE-1:0]   s_awlen,
  input  logic [NUM_CH-1:0]                  s_awvalid,
  output logic [NUM_CH-1:0]                  s_awready,
  input  logic [NUM_CH*AXI_DSIZE-1:0]        s_wdata,
  input  logic [NUM_CH-1:0]                  s_wlast,
  input  logic [NUM_CH-1:0]                  s_wvalid,
  output logic [NUM_CH-1:0]                  s_wready,
  output logic [NUM_CH*2-1:0]                s_bresp,
  output logic [NUM_CH-1:0]                  s_bvalid,
  input  logic [NUM_CH-1:0]                  s_bready,
  output logic [IDSIZE-1:0]                  m_awid,
  output logic [ASIZE-1:0]                   m_awaddr,
  output logic [BURST_LEN_SIZE-1:0]          m_awlen,
  output logic [2:0]                         m_awsize,
  output logic [1:0]                         m_awburst,
  output logic                               m_awvalid,
  input  logic                               m_awready,
  output logic [AXI_DSIZE-1:0]               m_wdata,
  output logic [AXI_DSIZE/8-1:0]             m_wstrb,
  output logic                               m_wlast,
  output logic                               m_wvalid,
  input  logic                               m_wready,
  input  logic [IDSIZE-1:0]                  m_bid,
  input  logic [1:0]                         m_bresp,
  input  logic                               m_bvalid,
  output logic                               m_bready
`ifdef VDMA_WR_ARB_LEN_CHK_EN
  ,
  output logic [NUM_CH-1:0]                  len_err
`endif
);

  localparam int OW = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [1:0]        state;
  logic [IDSIZE-1:0] grant;
  logic [IDSIZE-1:0] last_grant;
  logic [IDSIZE-1:0] next_grant;
  logic              any_elig;
  logic [NUM_CH-1:0] eligible;
  logic [OW-1:0]     outst [NUM_CH];
  logic [NUM_CH-1:0] outst_inc;
  logic [NUM_CH-1:0] outst_dec;
  logic              in_addr;
  logic              in_data;
  logic              aw_hs;
  logic              w_hs;
  logic              end_beat;

  assign in_addr = (state == ST_ADDR);
  assign in_data = (state == ST_DATA);
  assign aw_hs   = m_awvalid && m_awready;
  assign w_hs    = m_wvalid && m_wready;

  // A channel may compete only while it has room for another outstanding burst
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      eligible[i] = s_awvalid[i] && (outst[i] < OW'(MAX_OUTST));
    end
  end

  // Round-robin search starting just after the previous winner
  always_comb begin
    int idx;
    logic [IDSIZE-1:0] cand;
    any_elig   = 1'b0;
    next_grant = '0;
    idx        = 0;
    cand       = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx  = (int'(last_grant) + k) % NUM_CH;
      cand = idx[IDSIZE-1:0];
      if (!any_elig && eligible[cand]) begin
        any_elig   = 1'b1;
        next_grant = cand;
      end
    end
  end

  // AW and W muxing from the granted channel; payload is zero outside its phase
  always_comb begin
    m_awvalid = in_addr;
    m_awid    = in_addr ? grant : '0;
    m_awaddr  = in_addr ? s_awaddr[int'(grant)*ASIZE +: ASIZE] : '0;
    m_awlen   = in_addr ? s_awlen[int'(grant)*BURST_LEN_SIZE +: BURST_LEN_SIZE] : '0;
    m_awsize  = 3'($clog2(AXI_DSIZE/8));
    m_awburst = 2'b01;
    m_wvalid  = in_data && s_wvalid[grant];
    m_wdata   = in_data ? s_wdata[int'(grant)*AXI_DSIZE +: AXI_DSIZE] : '0;
    m_wstrb   = m_wvalid ? '1 : '0;
    s_awready = '0;
    s_wready  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      s_awready[i] = in_addr && (grant == IDSIZE'(i)) && m_awready;
      s_wready[i]  = in_data && (grant == IDSIZE'(i)) && m_wready;
    end
  end

`ifdef VDMA_WR_ARB_LEN_CHK_EN
  logic [BURST_LEN_SIZE-1:0] beat_cnt;
  logic [BURST_LEN_SIZE-1:0] burst_len;
  logic                      last_beat;

  assign last_beat = (beat_cnt == burst_len);
  assign end_beat  = last_beat;
  assign m_wlast   = in_data && last_beat;

  // Track beats of the current burst and flag any wlast that disagrees with awlen
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      beat_cnt  <= '0;
      burst_len <= '0;
      len_err   <= '0;
    end else begin
      if (aw_hs) begin
        burst_len <= m_awlen;
        beat_cnt  <= '0;
      end else if (w_hs) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (w_hs && (s_wlast[grant] != last_beat)) begin
        len_err[grant] <= 1'b1;
      end
    end
  end
`else
  assign end_beat = s_wlast[grant];
  assign m_wlast  = in_data && s_wlast[grant];
`endif

  // B routing by ID; responses for IDs beyond the channel range are absorbed
  always_comb begin
    s_bresp  = {NUM_CH{m_bresp}};
    s_bvalid = '0;
    m_bready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      s_bvalid[i] = m_bvalid && (m_bid == IDSIZE'(i));
      if (m_bid == IDSIZE'(i)) begin
        m_bready = s_bready[i];
      end
    end
  end

  // Per-channel counter increment/decrement requests
  always_comb begin
    outst_inc = '0;
    outst_dec = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      outst_inc[i] = aw_hs && (grant == IDSIZE'(i));
      outst_dec[i] = s_bvalid[i] && s_bready[i];
    end
  end

  // Outstanding burst counters; simultaneous AW and B cancel, no underflow
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        outst[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (outst_inc[i] && !outst_dec[i]) begin
          outst[i] <= outst[i] + 1'b1;
        end else if (outst_dec[i] && !outst_inc[i] && (outst[i] != '0)) begin
          outst[i] <= outst[i] - 1'b1;
        end
      end
    end
  end

  // Burst sequencing: grant in IDLE, issue AW in ADDR, forward beats in DATA
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_grant <= IDSIZE'(NUM_CH - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_elig) begin
            grant <= next_grant;
            state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (m_awready) begin
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_hs && end_beat) begin
            last_grant <= grant;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vdma_wr_port_arbiter.sv
// tb_vdma_wr_port_arbiter
// Directed bench for vdma_wr_port_arbiter. Main instance uses NUM_CH=4 and
// MAX_OUTST=2; a second NUM_CH=3 instance exercises out-of-range B IDs.
// Honours VDMA_WR_ARB_LEN_CHK_EN when it is defined for the build.
module tb_vdma_wr_port_arbiter;

  localparam int NCH = 4;
  localparam int AW  = 29;
  localparam int LW  = 8;
  localparam int DW  = 256;

  logic            clk;
  logic            axi_resetn;
  logic [NCH*AW-1:0] s_awaddr;
  logic [NCH*LW-1:0] s_awlen;
  logic [NCH-1:0]    s_awvalid;
  logic [NCH-1:0]    s_awready;
  logic [NCH*DW-1:0] s_wdata;
  logic [NCH-1:0]    s_wlast;
  logic [NCH-1:0]    s_wvalid;
  logic [NCH-1:0]    s_wready;
  logic [NCH*2-1:0]  s_bresp;
  logic [NCH-1:0]    s_bvalid;
  logic [NCH-1:0]    s_bready;
  logic [1:0]        m_awid;
  logic [AW-1:0]     m_awaddr;
  logic [LW-1:0]     m_awlen;
  logic [2:0]        m_awsize;
  logic [1:0]        m_awburst;
  logic              m_awvalid;
  logic              m_awready;
  logic [DW-1:0]     m_wdata;
  logic [DW/8-1:0]   m_wstrb;
  logic              m_wlast;
  logic              m_wvalid;
  logic              m_wready;
  logic [1:0]        m_bid;
  logic [1:0]        m_bresp;
  logic              m_bvalid;
  logic              m_bready;
`ifdef VDMA_WR_ARB_LEN_CHK_EN
  logic [NCH-1:0]    len_err;
  logic [2:0]        d_len_err;
`endif

  // Signals of the three-channel instance
  logic [3*AW-1:0]   d_awaddr;
  logic [3*LW-1:0]   d_awlen;
  logic [2:0]        d_awvalid;
  logic [2:0]        d_awready;
  logic [3*DW-1:0]   d_wdata;
  logic [2:0]        d_wlast;
  logic [2:0]        d_wvalid;
  logic [2:0]        d_wready;
  logic [5:0]        d_sbresp;
  logic [2:0]        d_sbvalid;
  logic [2:0]        d_sbready;
  logic [1:0]        d_awid;
  logic [AW-1:0]     d_maddr;
  logic [LW-1:0]     d_mlen;
  logic [2:0]        d_msize;
  logic [1:0]        d_mburst;
  logic              d_mawvalid;
  logic [DW-1:0]     d_mwdata;
  logic [DW/8-1:0]   d_mwstrb;
  logic              d_mwlast;
  logic              d_mwvalid;
  logic [1:0]        d_bid;
  logic              d_bvalid;
  logic              d_bready;

  int checks;
  int errors;

  vdma_wr_port_arbiter #(
    .NUM_CH(NCH), .ASIZE(AW), .BURST_LEN_SIZE(LW), .AXI_DSIZE(DW), .MAX_OUTST(2)
  ) u_dut (
    .axi_aclk(clk), .axi_resetn(axi_resetn),
    .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .m_wready(m_wready), .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid),
    .m_bready(m_bready)
`ifdef VDMA_WR_ARB_LEN_CHK_EN
    , .len_err(len_err)
`endif
  );

  vdma_wr_port_arbiter #(
    .NUM_CH(3), .ASIZE(AW), .BURST_LEN_SIZE(LW), .AXI_DSIZE(DW), .MAX_OUTST(2)
  ) u_drop (
    .axi_aclk(clk), .axi_resetn(axi_resetn),
    .s_awaddr(d_awaddr), .s_awlen(d_awlen), .s_awvalid(d_awvalid), .s_awready(d_awready),
    .s_wdata(d_wdata), .s_wlast(d_wlast), .s_wvalid(d_wvalid), .s_wready(d_wready),
    .s_bresp(d_sbresp), .s_bvalid(d_sbvalid), .s_bready(d_sbready),
    .m_awid(d_awid), .m_awaddr(d_maddr), .m_awlen(d_mlen), .m_awsize(d_msize),
    .m_awburst(d_mburst), .m_awvalid(d_mawvalid), .m_awready(1'b0),
    .m_wdata(d_mwdata), .m_wstrb(d_mwstrb), .m_wlast(d_mwlast), .m_wvalid(d_mwvalid),
    .m_wready(1'b0), .m_bid(d_bid), .m_bresp(2'b00), .m_bvalid(d_bvalid),
    .m_bready(d_bready)
`ifdef VDMA_WR_ARB_LEN_CHK_EN
    , .len_err(d_len_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clear_inputs;
    s_awaddr  = '0;
    s_awlen   = '0;
    s_awvalid = '0;
    s_wdata   = '0;
    s_wlast   = '0;
    s_wvalid  = '0;
    s_bready  = '0;
    m_awready = 1'b1;
    m_wready  = 1'b1;
    m_bid     = '0;
    m_bresp   = '0;
    m_bvalid  = 1'b0;
    d_awaddr  = '0;
    d_awlen   = '0;
    d_awvalid = '0;
    d_wdata   = '0;
    d_wlast   = '0;
    d_wvalid  = '0;
    d_sbready = '0;
    d_bid     = '0;
    d_bvalid  = 1'b0;
  endtask

  task automatic apply_reset;
    axi_resetn = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    axi_resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    s_awaddr[ch*AW +: AW] = addr;
    s_awlen[ch*LW +: LW]  = len;
  endtask

  // Waits up to 'limit' cycles for m_awvalid, sampled 1 time unit after the edge
  task automatic wait_aw(input int limit, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < limit && !seen; c++) begin
      @(posedge clk);
      #1;
      if (m_awvalid === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    axi_resetn = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (m_awvalid !== 1'b0 || m_wvalid !== 1'b0 || m_bready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_valids got aw=%b w=%b br=%b exp 0 0 0", m_awvalid, m_wvalid, m_bready);
    end
    checks++;
    if (s_awready !== 4'b0 || s_wready !== 4'b0 || s_bvalid !== 4'b0) begin
      errors++;
      $display("[TB] FAIL reset_slave_rdy got awr=%b wr=%b bv=%b exp 0", s_awready, s_wready, s_bvalid);
    end
    checks++;
    if (m_awaddr !== '0 || m_awlen !== '0 || m_awid !== '0 || m_wdata !== '0 || m_wstrb !== '0 || m_wlast !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_payload got addr=%h len=%h id=%h strb=%h exp 0", m_awaddr, m_awlen, m_awid, m_wstrb);
    end
    checks++;
    if (m_awsize !== 3'd5 || m_awburst !== 2'b01) begin
      errors++;
      $display("[TB] FAIL aw_consts got size=%0d burst=%b exp 5 01", m_awsize, m_awburst);
    end
    @(negedge clk);
    axi_resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_burst;
    logic [DW-1:0] exp_data;
    apply_reset();
    set_ch(0, 29'h100, 8'd3);
    s_awvalid = 4'b0001;
    checks++;
    if (m_awvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL aw_latency_early got %b exp 0", m_awvalid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (m_awvalid !== 1'b1 || m_awid !== 2'd0 || m_awaddr !== 29'h100 || m_awlen !== 8'd3) begin
      errors++;
      $display("[TB] FAIL aw_fields got v=%b id=%0d addr=%h len=%0d exp 1 0 100 3", m_awvalid, m_awid, m_awaddr, m_awlen);
    end
    checks++;
    if (s_awready !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL aw_ready got %b exp 0001", s_awready);
    end
    for (int b = 0; b < 4; b++) begin
      @(posedge clk);
      #1;
      s_awvalid = 4'b0000;
      exp_data = {8{32'hA000_0000 | 32'(b)}};
      s_wdata[0 +: DW] = exp_data;
      s_wvalid = 4'b0001;
      s_wlast  = (b == 3) ? 4'b0001 : 4'b0000;
      #1;
      checks++;
      if (m_wvalid !== 1'b1 || m_wdata !== exp_data || m_wstrb !== {(DW/8){1'b1}} || m_wlast !== (b == 3)) begin
        errors++;
        $display("[TB] FAIL w_beat%0d got v=%b last=%b strb=%h exp 1 %b all-ones", b, m_wvalid, m_wlast, m_wstrb, (b == 3));
      end
    end
    @(posedge clk);
    #1;
    s_wvalid = 4'b0000;
    s_wlast  = 4'b0000;
    #1;
    checks++;
    if (m_wvalid !== 1'b0 || m_wstrb !== '0 || m_awvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL burst_done got wv=%b strb=%h awv=%b exp 0 0 0", m_wvalid, m_wstrb, m_awvalid);
    end
  endtask

  task automatic test_round_robin;
    int exp_order [6] = '{0, 1, 2, 3, 0, 1};
    int n;
    int cur;
    apply_reset();
    for (int i = 0; i < NCH; i++) set_ch(i, 29'(32'h1000 * (i + 1)), 8'd0);
    s_awvalid = 4'b1111;
    s_wvalid  = 4'b1111;
    s_wlast   = 4'b1111;
    n   = 0;
    cur = 0;
    for (int c = 0; c < 60 && n < 6; c++) begin
      @(posedge clk);
      #1;
      if (m_awvalid === 1'b1) begin
        checks++;
        if (int'(m_awid) != exp_order[n]) begin
          errors++;
          $display("[TB] FAIL rr_order%0d got %0d exp %0d", n, m_awid, exp_order[n]);
        end
        cur = exp_order[n];
        n++;
      end
      if (m_wvalid === 1'b1) begin
        checks++;
        if (s_wready !== (4'b0001 << cur)) begin
          errors++;
          $display("[TB] FAIL w_lock got %b exp %b", s_wready, (4'b0001 << cur));
        end
      end
    end
    checks++;
    if (n != 6) begin
      errors++;
      $display("[TB] FAIL rr_count got %0d exp 6", n);
    end
    clear_inputs();
  endtask

  task automatic test_outstanding;
    int n;
    bit seen;
    apply_reset();
    set_ch(1, 29'h200, 8'd0);
    s_awvalid = 4'b0010;
    s_wvalid  = 4'b0010;
    s_wlast   = 4'b0010;
    n = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (m_awvalid === 1'b1) n++;
    end
    checks++;
    if (n != 2 || m_awvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL outst_stall got count=%0d awv=%b exp 2 0", n, m_awvalid);
    end
    m_bvalid = 1'b1;
    m_bid    = 2'd1;
    s_bready = 4'b0010;
    #1;
    checks++;
    if (s_bvalid !== 4'b0010 || m_bready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b_route1 got bv=%b br=%b exp 0010 1", s_bvalid, m_bready);
    end
    @(posedge clk);
    #1;
    m_bvalid = 1'b0;
    s_bready = 4'b0000;
    wait_aw(5, seen);
    checks++;
    if (!seen || m_awid !== 2'd1) begin
      errors++;
      $display("[TB] FAIL outst_release got seen=%0d id=%0d exp 1 1", seen, m_awid);
    end
    clear_inputs();
  endtask

  task automatic test_b_routing;
    apply_reset();
    m_bvalid = 1'b1;
    m_bid    = 2'd2;
    m_bresp  = 2'b10;
    s_bready = 4'b0000;
    #1;
    checks++;
    if (m_bready !== 1'b0 || s_bvalid !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL b_route2 got br=%b bv=%b exp 0 0100", m_bready, s_bvalid);
    end
    checks++;
    if (s_bresp !== 8'b10101010) begin
      errors++;
      $display("[TB] FAIL b_resp got %b exp 10101010", s_bresp);
    end
    s_bready = 4'b1011;
    #1;
    checks++;
    if (m_bready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b_ready_sel got %b exp 0", m_bready);
    end
    s_bready = 4'b0100;
    #1;
    checks++;
    if (m_bready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b_ready_pass got %b exp 1", m_bready);
    end
    m_bvalid  = 1'b0;
    s_bready  = 4'b0000;
    d_bvalid  = 1'b1;
    d_bid     = 2'd3;
    d_sbready = 3'b000;
    #1;
    checks++;
    if (d_bready !== 1'b1 || d_sbvalid !== 3'b000) begin
      errors++;
      $display("[TB] FAIL b_drop got br=%b bv=%b exp 1 000", d_bready, d_sbvalid);
    end
    d_bvalid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_burst;
    bit seen;
    apply_reset();
    set_ch(0, 29'h300, 8'd7);
    set_ch(1, 29'h400, 8'd0);
    s_awvalid = 4'b0001;
    wait_aw(5, seen);
    @(posedge clk);
    #1;
    s_awvalid = 4'b0000;
    s_wvalid  = 4'b0001;
    s_wlast   = 4'b0000;
    @(posedge clk);
    #1;
    checks++;
    if (!seen || m_wvalid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midburst_active got seen=%0d wv=%b exp 1 1", seen, m_wvalid);
    end
    #2;
    axi_resetn = 1'b0;
    #1;
    checks++;
    if (m_wvalid !== 1'b0 || m_awvalid !== 1'b0 || s_wready !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL async_reset got wv=%b awv=%b wr=%b exp 0 0 0", m_wvalid, m_awvalid, s_wready);
    end
    @(negedge clk);
    axi_resetn = 1'b1;
    s_wvalid  = 4'b0000;
    s_awvalid = 4'b0011;
    wait_aw(5, seen);
    checks++;
    if (!seen || m_awid !== 2'd0) begin
      errors++;
      $display("[TB] FAIL post_reset_grant got seen=%0d id=%0d exp 1 0", seen, m_awid);
    end
    clear_inputs();
  endtask

`ifdef VDMA_WR_ARB_LEN_CHK_EN
  task automatic test_len_check;
    bit seen;
    apply_reset();
    set_ch(0, 29'h500, 8'd3);
    s_awvalid = 4'b0001;
    wait_aw(5, seen);
    for (int b = 0; b < 4; b++) begin
      @(posedge clk);
      #1;
      s_awvalid = 4'b0000;
      s_wvalid  = 4'b0001;
      s_wlast   = (b == 1) ? 4'b0001 : 4'b0000;
      #1;
      checks++;
      if (m_wvalid !== 1'b1 || m_wlast !== (b == 3)) begin
        errors++;
        $display("[TB] FAIL len_beat%0d got v=%b last=%b exp 1 %b", b, m_wvalid, m_wlast, (b == 3));
      end
    end
    @(posedge clk);
    #1;
    s_wvalid = 4'b0000;
    s_wlast  = 4'b0000;
    checks++;
    if (len_err !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL len_err_set got %b exp 0001", len_err);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (len_err !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL len_err_sticky got %b exp 0001", len_err);
    end
    clear_inputs();
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    axi_resetn = 1'b0;
    clear_inputs();
    test_reset();
    test_single_burst();
    test_round_robin();
    test_outstanding();
    test_b_routing();
    test_reset_mid_burst();
`ifdef VDMA_WR_ARB_LEN_CHK_EN
    test_len_check();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
